// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the accumulator CPU: opcode encodings (also used as
// ALU function codes), accumulator source selects and PC jump source selects.
// Imported by cpu_alu, cpu_datapath and the controller.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_W   = 4;
  localparam int OPND_W  = 4;
  localparam int NUM_REGS = 16;

  // Opcodes. ADD/SUB/NOR/SHFL/SHFR double as ALU function codes; every other
  // code makes the ALU pass the accumulator through unchanged.
  typedef enum logic [OPC_W-1:0] {
    NOP  = 4'b0000,
    ADD  = 4'b0001,
    SUB  = 4'b0010,
    NOR  = 4'b0011,
    LDR  = 4'b0100,  // ACC <= R[opnd]
    STR  = 4'b0101,  // R[opnd] <= ACC
    JMPI = 4'b0110,  // PC <= imm
    JMPR = 4'b0111,  // PC <= R[opnd]
    JZ   = 4'b1000,
    JC   = 4'b1001,
    SHFL = 4'b1011,
    SHFR = 4'b1100,
    LDI  = 4'b1101,  // ACC <= imm
    HALT = 4'b1111
  } opcode_e;

  // Accumulator source select.
  typedef enum logic [1:0] {
    ACC_ALU  = 2'b00,
    ACC_REG  = 2'b01,
    ACC_IMM  = 2'b10,
    ACC_HOLD = 2'b11
  } sel_acc_e;

  // Jump source select.
  localparam logic PC_SRC_REG = 1'b0;
  localparam logic PC_SRC_IMM = 1'b1;

endpackage

// File: rtl/cpu_alu.sv
// -----------------------------------------------------------------------------
// cpu_alu
// Purely combinational ALU. a is the register-file operand, b the accumulator.
// Ports:
//   a, b    in  DATA_W : operands
//   SelALU  in  4      : function code (opcode encoding)
//   result  out DATA_W : result, truncated to DATA_W
//   cout    out 1      : carry (ADD), borrow (SUB) or shifted-out bit
// -----------------------------------------------------------------------------
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OPC_W-1:0]  SelALU,
  output logic [DATA_W-1:0] result,
  output logic              cout
);

  // One bit wider so the carry out of the add is kept.
  logic [DATA_W:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    result = b;
    cout   = 1'b0;
    case (opcode_e'(SelALU))
      ADD: begin
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
      end
      SUB: begin
        result = a - b;
        cout   = (a < b);
      end
      NOR: begin
        result = ~(a | b);
      end
      SHFR: begin
        result = b >> 1;
        cout   = b[0];
      end
      SHFL: begin
        result = b << 1;
        cout   = b[DATA_W-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// -----------------------------------------------------------------------------
// cpu_datapath
// Execution datapath of the accumulator CPU: PC, IR, ACC, carry flag, a
// 16-entry register file and the ALU. Driven by controller strobes; returns
// Opcode, Z and C to the controller.
// Ports:
//   Clk, CLB      : rising-edge clock, asynchronous active-low clear
//   Instr  in 8   : instruction at address PC (opcode [7:4], operand [3:0])
//   PC     out    : program counter / instruction-memory address
//   LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU : strobes
//   Opcode out 4  : IR[7:4]
//   Z, C   out 1  : accumulator zero, carry/borrow
//   Acc    out    : accumulator value
// -----------------------------------------------------------------------------
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic               Clk,
  input  logic               CLB,
  input  logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    PC,
  input  logic               LoadIR,
  input  logic               IncPC,
  input  logic               SelPC,
  input  logic               LoadPC,
  input  logic               LoadReg,
  input  logic               LoadAcc,
  input  logic [1:0]         SelAcc,
  input  logic [OPC_W-1:0]   SelALU,
  output logic [OPC_W-1:0]   Opcode,
  output logic               Z,
  output logic               C,
  output logic [DATA_W-1:0]  Acc
);

  logic [PC_W-1:0]    pc_q,  pc_d;
  logic [INSTR_W-1:0] ir_q,  ir_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               c_q,   c_d;
  logic [DATA_W-1:0]  rf_q [NUM_REGS];
  logic [DATA_W-1:0]  rf_d [NUM_REGS];

  // All operand uses come from the current IR, so a LoadIR in the same cycle
  // as a register/accumulator write only affects the following cycle.
  logic [OPND_W-1:0] opnd;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] alu_result;
  logic              alu_cout;

  assign opnd    = ir_q[OPND_W-1:0];
  assign rd_data = rf_q[opnd];

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (rd_data),
    .b      (acc_q),
    .SelALU (SelALU),
    .result (alu_result),
    .cout   (alu_cout)
  );

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    acc_d = acc_q;
    c_d   = c_q;
    rf_d  = rf_q;

    // Jump beats increment.
    if (LoadPC) begin
      pc_d = (SelPC == PC_SRC_IMM) ? PC_W'(opnd) : PC_W'(rd_data);
    end else if (IncPC) begin
      pc_d = pc_q + PC_W'(1);
    end

    if (LoadIR) begin
      ir_d = Instr;
    end

    // Register write takes the old ACC even if ACC is loaded this cycle.
    if (LoadReg) begin
      rf_d[opnd] = acc_q;
    end

    // Only an ALU load touches the carry flag.
    if (LoadAcc) begin
      case (sel_acc_e'(SelAcc))
        ACC_ALU: begin
          acc_d = alu_result;
          c_d   = alu_cout;
        end
        ACC_REG: acc_d = rd_data;
        ACC_IMM: acc_d = DATA_W'(opnd);
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge CLB) begin
    if (!CLB) begin
      pc_q  <= '0;
      ir_q  <= '0;
      acc_q <= '0;
      c_q   <= 1'b0;
      // NOTE: the register file is cleared on reset because the CPU
      // architecture defines R[i] = 0 after clear; this keeps it in flops
      // rather than a RAM macro, which is fine at 16 entries.
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      acc_q <= acc_d;
      c_q   <= c_d;
      rf_q  <= rf_d;
    end
  end

  assign PC     = pc_q;
  assign Opcode = ir_q[INSTR_W-1:INSTR_W-OPC_W];
  assign Acc    = acc_q;
  assign Z      = (acc_q == '0);
  assign C      = c_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// -----------------------------------------------------------------------------
// tb_cpu_datapath
// Directed scenarios plus randomized strobes, checked against a behavioural
// model of the datapath (integer state, plain arithmetic).
// -----------------------------------------------------------------------------
module tb_cpu_datapath;
  import cpu_pkg::*;

  logic       Clk = 1'b0;
  logic       CLB;
  logic [7:0] Instr;
  logic [7:0] PC;
  logic       LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic [3:0] Opcode;
  logic       Z, C;
  logic [7:0] Acc;

  cpu_datapath #(.DATA_W(8), .PC_W(8)) dut (
    .Clk(Clk), .CLB(CLB), .Instr(Instr), .PC(PC),
    .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
    .Opcode(Opcode), .Z(Z), .C(C), .Acc(Acc)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pc, m_ir, m_acc, m_c;
  int m_r [16];

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_acc = 0; m_c = 0;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
  endtask

  task automatic model_compare(input string where);
    check({where, ".pc"},     32'(PC),     32'(m_pc));
    check({where, ".opcode"}, 32'(Opcode), 32'(m_ir / 16));
    check({where, ".acc"},    32'(Acc),    32'(m_acc));
    check({where, ".z"},      32'(Z),      32'(m_acc == 0));
    check({where, ".c"},      32'(C),      32'(m_c));
  endtask

  // Apply one cycle of strobes: drive, predict, clock, compare.
  task automatic cycle(input bit lir, input int ins, input bit lacc, input int sacc,
                       input int salu, input bit lreg, input bit lpc, input bit spc,
                       input bit ipc);
    int opnd, a, b, res, co, n_pc, n_ir, n_acc, n_c;
    LoadIR = lir; Instr = 8'(ins); LoadAcc = lacc; SelAcc = 2'(sacc);
    SelALU = 4'(salu); LoadReg = lreg; LoadPC = lpc; SelPC = spc; IncPC = ipc;

    opnd = m_ir % 16;
    a    = m_r[opnd];
    b    = m_acc;
    case (salu)
      1:  begin res = (a + b) % 256;       co = (a + b) / 256;  end
      2:  begin res = (a - b + 256) % 256; co = (a < b) ? 1 : 0; end
      3:  begin res = 255 - (a | b);       co = 0;             end
      12: begin res = b / 2;               co = b % 2;         end
      11: begin res = (b * 2) % 256;       co = b / 128;       end
      default: begin res = b;              co = 0;             end
    endcase

    n_pc = m_pc;
    if (lpc)      n_pc = spc ? opnd : a;
    else if (ipc) n_pc = (m_pc + 1) % 256;
    n_ir  = lir ? ins : m_ir;
    n_acc = m_acc;
    n_c   = m_c;
    if (lacc) begin
      if (sacc == 0) begin n_acc = res; n_c = co; end
      else if (sacc == 1) n_acc = a;
      else if (sacc == 2) n_acc = opnd;
    end

    @(posedge Clk);
    #1;
    if (lreg) m_r[opnd] = m_acc;
    m_pc = n_pc; m_ir = n_ir; m_acc = n_acc; m_c = n_c;
    model_compare("model");
  endtask

  task automatic idle_inputs();
    LoadIR = 0; Instr = 0; LoadAcc = 0; SelAcc = 0; SelALU = 0;
    LoadReg = 0; LoadPC = 0; SelPC = 0; IncPC = 0;
  endtask

  task automatic set_ir(input int ins);   cycle(1, ins, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic acc_imm();               cycle(0, 0, 1, 2, 0, 0, 0, 0, 0);   endtask
  task automatic acc_reg();               cycle(0, 0, 1, 1, 0, 0, 0, 0, 0);   endtask
  task automatic acc_alu(input int op);   cycle(0, 0, 1, 0, op, 0, 0, 0, 0);  endtask
  task automatic store_reg();             cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);   endtask
  task automatic jump_reg();              cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);   endtask

  // Asynchronous clear between edges: outputs must clear before any edge.
  task automatic async_clear(input string where);
    #2;
    CLB = 1'b0;
    #1;
    check({where, ".pc"},     32'(PC),     32'h0);
    check({where, ".opcode"}, 32'(Opcode), 32'h0);
    check({where, ".acc"},    32'(Acc),    32'h0);
    check({where, ".z"},      32'(Z),      32'h1);
    check({where, ".c"},      32'(C),      32'h0);
    model_reset();
    idle_inputs();
    @(negedge Clk);
    CLB = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    CLB = 1'b0;
    #12;
    check("rst.pc",     32'(PC),     32'h0);
    check("rst.opcode", 32'(Opcode), 32'h0);
    check("rst.acc",    32'(Acc),    32'h0);
    check("rst.z",      32'(Z),      32'h1);
    check("rst.c",      32'(C),      32'h0);
    @(negedge Clk);
    CLB = 1'b1;

    // Mid-run clear at PC = 0x23.
    for (int i = 0; i < 35; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("pc_before_clear", 32'(PC), 32'h23);
    async_clear("midclr");

    // Fetch + immediate load.
    cycle(1, 8'hD5, 0, 0, 0, 0, 0, 0, 1);
    check("fetch.opcode", 32'(Opcode), 32'hD);
    check("fetch.pc",     32'(PC),     32'h1);
    acc_imm();
    check("ldi.acc", 32'(Acc), 32'h05);
    check("ldi.z",   32'(Z),   32'h0);

    // Add with carry: R3 = 0xF0, ACC = 0x20.
    set_ir(8'hDF); acc_imm();
    for (int i = 0; i < 4; i++) acc_alu(SHFL);
    set_ir(8'h53); store_reg();
    set_ir(8'hD2); acc_imm();
    for (int i = 0; i < 4; i++) acc_alu(SHFL);
    check("pre_add.acc", 32'(Acc), 32'h20);
    set_ir(8'h13); acc_alu(ADD);
    check("add.acc", 32'(Acc), 32'h10);
    check("add.c",   32'(C),   32'h1);
    acc_imm();
    check("imm_keeps_c.acc", 32'(Acc), 32'h03);
    check("imm_keeps_c.c",   32'(C),   32'h1);

    // Subtract with borrow: R1 = 3, ACC = 5.
    set_ir(8'h51); store_reg();
    set_ir(8'hD5); acc_imm();
    set_ir(8'h21); acc_alu(SUB);
    check("sub.acc", 32'(Acc), 32'hFE);
    check("sub.c",   32'(C),   32'h1);

    // NOR to zero with C set beforehand.
    set_ir(8'hD0); acc_imm();
    set_ir(8'h35); acc_alu(NOR);
    check("nor_ff.acc", 32'(Acc), 32'hFF);
    set_ir(8'h56); store_reg();
    acc_alu(SHFR);
    check("shfr_ff.c", 32'(C), 32'h1);
    acc_alu(NOR);
    check("nor0.acc", 32'(Acc), 32'h00);
    check("nor0.z",   32'(Z),   32'h1);
    check("nor0.c",   32'(C),   32'h0);

    // Jumps.
    set_ir(8'h6A);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 1);
    check("jmp_imm.pc", 32'(PC), 32'h0A);
    set_ir(8'hDC); acc_imm();
    set_ir(8'h52); store_reg();
    set_ir(8'hD7); acc_imm();
    for (int i = 0; i < 4; i++) acc_alu(SHFL);
    set_ir(8'h12); acc_alu(ADD);
    set_ir(8'h57); store_reg();
    jump_reg();
    check("jmp_reg.pc", 32'(PC), 32'h7C);
    set_ir(8'h66); jump_reg();
    check("jmp_ff.pc", 32'(PC), 32'hFF);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("pc_wrap", 32'(PC), 32'h00);

    // Simultaneous register write and SHFL on 0x81.
    set_ir(8'hD1); acc_imm();
    set_ir(8'h58); store_reg();
    set_ir(8'hD8); acc_imm();
    for (int i = 0; i < 4; i++) acc_alu(SHFL);
    set_ir(8'h18); acc_alu(ADD);
    check("pre_shfl.acc", 32'(Acc), 32'h81);
    set_ir(8'hB9);
    cycle(0, 0, 1, 0, SHFL, 1, 0, 0, 0);
    check("shfl.acc", 32'(Acc), 32'h02);
    check("shfl.c",   32'(C),   32'h1);
    acc_reg();
    check("shfl.reg_old_acc", 32'(Acc), 32'h81);
    set_ir(8'hD1); acc_imm();
    acc_alu(SHFR);
    check("shfr1.acc", 32'(Acc), 32'h00);
    check("shfr1.c",   32'(C),   32'h1);
    check("shfr1.z",   32'(Z),   32'h1);

    // Hold select with LoadAcc keeps ACC.
    cycle(0, 0, 1, 3, ADD, 0, 0, 0, 0);
    check("hold.acc", 32'(Acc), 32'h00);

    // Randomized strobes.
    for (int i = 0; i < 1500; i++) begin
      automatic int alu_ops[6] = '{1, 2, 3, 11, 12, 7};
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 3),
            alu_ops[$urandom_range(0, 5)], $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1),
            $urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) async_clear("rand_clr");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
